// File: rtl/dot4x_clk_pkg.sv
// Shared types and helpers for the dot4x clock sequencer.
// States, video standard codes and counter sizing.
package dot4x_clk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT_RST,
    WAIT_LOCK,
    RELEASE,
    RUN,
    FAULT
  } state_e;

  localparam logic [1:0] STD_NTSC = 2'd0;
  localparam logic [1:0] STD_PAL  = 2'd1;

  // Reserved codes fall back to NTSC
  function automatic logic [1:0] std_map(
    input logic [1:0] s
  );
    return (s == STD_PAL) ? STD_PAL : STD_NTSC;
  endfunction

  function automatic int cnt_w(input int max_v);
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/dot4x_clock_sequencer_sync_2ff.sv
// Two-flop synchroniser for single-bit async inputs.
// Async active-low reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dot4x_clock_sequencer.sv
// MMCM bring-up sequencer: reset hold, lock qualify, retry,
// staggered domain reset release and re-sequencing.
module dot4x_clock_sequencer
  import dot4x_clk_pkg::*;
#(
  parameter int NUM_DOMAINS  = 2,
  parameter int RST_HOLD     = 16,
  parameter int LOCK_STABLE  = 256,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int STAGGER      = 8,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                   clk_in,
  input  logic                   reset_n,
  input  logic                   locked,
  input  logic [1:0]             std_sel,
  output logic                   mmcm_reset,
  output logic [1:0]             std_active,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   ready,
  output logic                   fault,
  output logic [3:0]             retry_count
);

  localparam int GMAX_I = (NUM_DOMAINS - 1) * STAGGER;
  localparam int HW = cnt_w(RST_HOLD - 1);
  localparam int SW = cnt_w(LOCK_STABLE);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam int GW = cnt_w(GMAX_I);

  localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_HOLD - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE);
  localparam logic [TW-1:0] TO_MAX     = TW'(LOCK_TIMEOUT);
  localparam logic [GW-1:0] GMAX       = GW'(GMAX_I);

  state_e state_q, state_d;

  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [GW-1:0] stagger_q, stagger_d;

  logic       locked_s;
  logic [1:0] std_q;
  logic       std_chg;
  logic [3:0] retry_inc;

  logic                   mmcm_d;
  logic [NUM_DOMAINS-1:0] dom_d;
  logic                   ready_d;
  logic                   fault_d;
  logic [1:0]             std_act_d;
  logic [3:0]             retry_d;

  sync_2ff u_lock_sync (
    .clk   (clk_in),
    .rst_n (reset_n),
    .d     (locked),
    .q     (locked_s)
  );

  assign std_chg = (std_q != std_active);

  assign retry_inc = (retry_count == 4'hf)
                   ? retry_count
                   : retry_count + 4'd1;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      stable_q     <= '0;
      timeout_q    <= '0;
      stagger_q    <= '0;
      std_q        <= STD_NTSC;
      mmcm_reset   <= 1'b1;
      domain_reset <= '1;
      ready        <= 1'b0;
      fault        <= 1'b0;
      std_active   <= STD_NTSC;
      retry_count  <= 4'd0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      stable_q     <= stable_d;
      timeout_q    <= timeout_d;
      stagger_q    <= stagger_d;
      std_q        <= std_map(std_sel);
      mmcm_reset   <= mmcm_d;
      domain_reset <= dom_d;
      ready        <= ready_d;
      fault        <= fault_d;
      std_active   <= std_act_d;
      retry_count  <= retry_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = '0;
    stable_d  = '0;
    timeout_d = '0;
    stagger_d = '0;
    unique case (state_q)
      IDLE: state_d = ASSERT_RST;
      ASSERT_RST: begin
        hold_d = (hold_q == HOLD_LAST)
               ? hold_q : hold_q + 1'b1;
        if (std_chg)
          state_d = IDLE;
        else if (hold_q == HOLD_LAST)
          state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (locked_s)
          stable_d = (stable_q == STABLE_MAX)
                   ? stable_q : stable_q + 1'b1;
        timeout_d = (timeout_q == TO_MAX)
                  ? timeout_q : timeout_q + 1'b1;
        if (std_chg)
          state_d = IDLE;
        else if (stable_d == STABLE_MAX)
          state_d = RELEASE;
        else if (timeout_d == TO_MAX)
          state_d = (retry_inc == 4'(MAX_RETRIES))
                  ? FAULT : ASSERT_RST;
      end
      RELEASE: begin
        stagger_d = (stagger_q == GMAX)
                  ? stagger_q : stagger_q + 1'b1;
        if (std_chg)
          state_d = IDLE;
        else if (!locked_s)
          state_d = ASSERT_RST;
        else if (stagger_q == GMAX)
          state_d = RUN;
      end
      RUN: begin
        if (std_chg)
          state_d = IDLE;
        else if (!locked_s)
          state_d = ASSERT_RST;
      end
      FAULT: begin
        if (std_chg)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Every state entry starts its counters from zero
    if (state_d != state_q) begin
      hold_d    = '0;
      stable_d  = '0;
      timeout_d = '0;
      stagger_d = '0;
    end
  end

  always_comb begin
    mmcm_d    = (state_d == IDLE)
             || (state_d == ASSERT_RST)
             || (state_d == FAULT);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
    std_act_d = (state_q == IDLE) ? std_q : std_active;
    retry_d   = retry_count;
    dom_d     = '1;
    if (state_d == RUN)
      dom_d = '0;
    else if (state_d == RELEASE)
      for (int i = 0; i < NUM_DOMAINS; i++)
        dom_d[i] = (i * STAGGER) > int'(stagger_d);
    if (state_q == WAIT_LOCK) begin
      if (state_d == RELEASE)
        retry_d = 4'd0;
      else if (state_d == FAULT || state_d == ASSERT_RST)
        retry_d = retry_inc;
    end
    if (state_q == FAULT && state_d == IDLE)
      retry_d = 4'd0;
  end

endmodule

// File: tb/tb_dot4x_clock_sequencer.sv
// Directed bench for dot4x_clock_sequencer with a phase/elapsed-time
// reference model compared every cycle, plus hand-computed checkpoints.
module tb_dot4x_clock_sequencer;

  localparam int ND  = 3;
  localparam int RH  = 4;
  localparam int LS  = 8;
  localparam int LT  = 40;
  localparam int STG = 3;
  localparam int MR  = 2;

  localparam int P_IDLE  = 0;
  localparam int P_HOLD  = 1;
  localparam int P_WAIT  = 2;
  localparam int P_REL   = 3;
  localparam int P_RUN   = 4;
  localparam int P_FAULT = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          locked = 1'b0;
  logic [1:0]    std_sel = 2'd0;
  logic          mmcm_reset;
  logic [1:0]    std_active;
  logic [ND-1:0] domain_reset;
  logic          ready;
  logic          fault;
  logic [3:0]    retry_count;

  int tests = 0;
  int fails = 0;
  int ecount = 0;

  int         m_ph = P_IDLE;
  int         m_t = 0;
  int         m_run = 0;
  int         m_retry = 0;
  logic [1:0] m_std = 2'd0;
  logic [1:0] m_sq = 2'd0;
  logic       m_l1 = 1'b0;
  logic       m_l2 = 1'b0;

  dot4x_clock_sequencer #(
    .NUM_DOMAINS  (ND),
    .RST_HOLD     (RH),
    .LOCK_STABLE  (LS),
    .LOCK_TIMEOUT (LT),
    .STAGGER      (STG),
    .MAX_RETRIES  (MR)
  ) dut (
    .clk_in       (clk),
    .reset_n      (rst_n),
    .locked       (locked),
    .std_sel      (std_sel),
    .mmcm_reset   (mmcm_reset),
    .std_active   (std_active),
    .domain_reset (domain_reset),
    .ready        (ready),
    .fault        (fault),
    .retry_count  (retry_count)
  );

  always #5 clk = ~clk;

  task automatic go(input int p);
    m_ph  = p;
    m_t   = 0;
    m_run = 0;
  endtask

  // Reference model: phase plus cycles elapsed in that phase
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        go(P_IDLE);
        m_retry = 0;
        m_std   = 2'd0;
        m_sq    = 2'd0;
        m_l1    = 1'b0;
        m_l2    = 1'b0;
        ecount  = 0;
      end else begin
        automatic logic ls = m_l2;
        automatic logic [1:0] sq = m_sq;
        ecount++;
        if (m_ph != P_IDLE && sq != m_std) begin
          if (m_ph == P_FAULT) m_retry = 0;
          go(P_IDLE);
        end else begin
          case (m_ph)
            P_IDLE: begin
              m_std = sq;
              go(P_HOLD);
            end
            P_HOLD:
              if (m_t == RH - 1) go(P_WAIT);
              else m_t++;
            P_WAIT: begin
              m_run = ls ? m_run + 1 : 0;
              if (m_run >= LS) begin
                m_retry = 0;
                go(P_REL);
              end else if (m_t + 1 >= LT) begin
                m_retry++;
                go(m_retry >= MR ? P_FAULT : P_HOLD);
              end else begin
                m_t++;
              end
            end
            P_REL:
              if (!ls) go(P_HOLD);
              else if (m_t == (ND - 1) * STG) go(P_RUN);
              else m_t++;
            P_RUN:
              if (!ls) go(P_HOLD);
            default: ;
          endcase
        end
        m_l2 = m_l1;
        m_l1 = locked;
        m_sq = (std_sel == 2'd1) ? 2'd1 : 2'd0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        automatic logic [ND-1:0] ed;
        automatic logic em = (m_ph == P_IDLE) || (m_ph == P_HOLD)
                          || (m_ph == P_FAULT);
        automatic logic er = (m_ph == P_RUN);
        automatic logic ef = (m_ph == P_FAULT);
        for (int i = 0; i < ND; i++)
          ed[i] = (m_ph == P_RUN) ? 1'b0
                : (m_ph == P_REL) ? (m_t < i * STG) : 1'b1;
        tests++;
        if (mmcm_reset !== em || domain_reset !== ed ||
            ready !== er || fault !== ef ||
            std_active !== m_std ||
            int'(retry_count) != m_retry) begin
          fails++;
          $display("FAIL model edge %0d: got mmcm=%b dom=%b rdy=%b flt=%b std=%0d retry=%0d, want %b %b %b %b %0d %0d",
                   ecount, mmcm_reset, domain_reset, ready, fault,
                   std_active, retry_count, em, ed, er, ef, m_std,
                   m_retry);
        end
      end
    end
  end

  task automatic chk(input string name, input int act,
                     input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic to_edge(input int n);
    int guard = 0;
    while (ecount < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (ecount != n) begin
      tests++;
      fails++;
      $display("FAIL to_edge: got %0d, want %0d", ecount, n);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    locked  = 1'b0;
    std_sel = 2'd0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset values while reset_n is low
    #7;
    chk("rst mmcm", int'(mmcm_reset), 1);
    chk("rst dom", int'(domain_reset), 7);
    chk("rst ready", int'(ready), 0);
    chk("rst fault", int'(fault), 0);
    chk("rst retry", int'(retry_count), 0);

    // Nominal bring-up, lock loss, standard switch, async reset
    do_reset();
    to_edge(4);
    chk("nom mmcm@4", int'(mmcm_reset), 1);
    to_edge(5);
    chk("nom mmcm@5", int'(mmcm_reset), 0);
    to_edge(10);
    locked = 1'b1;
    to_edge(19);
    chk("nom dom@19", int'(domain_reset), 7);
    to_edge(20);
    chk("nom dom@20", int'(domain_reset), 6);
    to_edge(23);
    chk("nom dom@23", int'(domain_reset), 4);
    to_edge(26);
    chk("nom dom@26", int'(domain_reset), 0);
    chk("nom rdy@26", int'(ready), 0);
    to_edge(27);
    chk("nom rdy@27", int'(ready), 1);
    chk("nom retry", int'(retry_count), 0);
    to_edge(35);
    locked = 1'b0;
    to_edge(37);
    chk("loss rdy@37", int'(ready), 1);
    to_edge(38);
    chk("loss rdy@38", int'(ready), 0);
    chk("loss mmcm@38", int'(mmcm_reset), 1);
    chk("loss dom@38", int'(domain_reset), 7);
    to_edge(40);
    locked = 1'b1;
    to_edge(57);
    chk("relock rdy@57", int'(ready), 1);
    to_edge(60);
    std_sel = 2'd1;
    to_edge(62);
    chk("sw rdy@62", int'(ready), 0);
    chk("sw std@62", int'(std_active), 0);
    to_edge(63);
    chk("sw std@63", int'(std_active), 1);
    to_edge(75);
    chk("sw dom@75", int'(domain_reset), 6);
    to_edge(76);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst mmcm", int'(mmcm_reset), 1);
    chk("arst dom", int'(domain_reset), 7);
    chk("arst std", int'(std_active), 0);
    chk("arst ready", int'(ready), 0);
    #1 rst_n = 1'b1;
    to_edge(30);
    chk("arst rdy@30", int'(ready), 1);
    chk("arst std@30", int'(std_active), 1);

    // Glitchy lock: 7 high, 1 low, then steady
    do_reset();
    to_edge(10);
    locked = 1'b1;
    to_edge(17);
    locked = 1'b0;
    to_edge(18);
    locked = 1'b1;
    to_edge(27);
    chk("glitch dom@27", int'(domain_reset), 7);
    to_edge(28);
    chk("glitch dom@28", int'(domain_reset), 6);
    chk("glitch retry", int'(retry_count), 0);
    to_edge(35);
    chk("glitch rdy@35", int'(ready), 1);

    // Timeout, retry, fault, exit on standard change
    do_reset();
    to_edge(44);
    chk("to retry@44", int'(retry_count), 0);
    chk("to mmcm@44", int'(mmcm_reset), 0);
    to_edge(45);
    chk("to retry@45", int'(retry_count), 1);
    chk("to mmcm@45", int'(mmcm_reset), 1);
    to_edge(48);
    chk("to mmcm@48", int'(mmcm_reset), 1);
    to_edge(49);
    chk("to mmcm@49", int'(mmcm_reset), 0);
    to_edge(88);
    chk("to fault@88", int'(fault), 0);
    to_edge(89);
    chk("to fault@89", int'(fault), 1);
    chk("to retry@89", int'(retry_count), 2);
    to_edge(120);
    chk("to fault@120", int'(fault), 1);
    std_sel = 2'd1;
    to_edge(122);
    chk("fsw fault@122", int'(fault), 0);
    chk("fsw retry@122", int'(retry_count), 0);
    to_edge(123);
    chk("fsw std@123", int'(std_active), 1);
    locked = 1'b1;
    to_edge(141);
    chk("fsw rdy@141", int'(ready), 0);
    to_edge(142);
    chk("fsw rdy@142", int'(ready), 1);
    to_edge(150);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dot4x_clock_sequencer.md
Name: dot4x_clock_sequencer

Overview:
- Parametrised successor to the fixed NTSC dot4x/col16x MMCM wrapper. It sequences MMCM bring-up for any video standard and any number of downstream clock domains.
- Runs on the free-running crystal input clock. Drives the MMCM reset, qualifies LOCKED with a stability filter and a timeout, and retries on failure.
- Releases per-domain resets in a staggered order and re-sequences on lock loss or on a video-standard change.
- Sits between the board oscillator/MMCM primitive and the top-level reset tree.

Parameters:
- NUM_DOMAINS, 2: number of downstream reset outputs (1..8).
- RST_HOLD, 16: clk_in cycles that mmcm_reset is held high per attempt (>=1).
- LOCK_STABLE, 256: consecutive synchronised-locked cycles required before lock is qualified (>=1).
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT_LOCK before an attempt fails (> LOCK_STABLE).
- STAGGER, 8: cycles between successive domain reset releases (>=1).
- MAX_RETRIES, 3: failed attempts tolerated before entering FAULT (1..15).

Ports:
- clk_in, input, 1: free-running input clock (14.318181 or 17.734475 MHz).
- reset_n, input, 1: asynchronous active-low reset.
- locked, input, 1: MMCM LOCKED, asynchronous to clk_in.
- std_sel, input, 2: requested video standard (0 NTSC, 1 PAL, 2/3 reserved, treated as 0); quasi-static.
- mmcm_reset, output, 1: active-high MMCM RST.
- std_active, output, 2: standard applied to the current attempt; selects the MMCM configuration.
- domain_reset, output, NUM_DOMAINS: active-high per-domain resets; bit 0 releases first.
- ready, output, 1: all domains out of reset and lock qualified.
- fault, output, 1: retries exhausted.
- retry_count, output, 4: failed attempts since the last successful lock.

Behaviour:
- Async reset (reset_n low) values:
  - state IDLE, mmcm_reset=1, domain_reset=all 1s, ready=0, fault=0, std_active=0, retry_count=0.
  - All counters 0; synchroniser flops 0.
- locked passes through a 2-flop synchroniser (locked_s) before any use, so an edge on locked is seen 2 cycles later.
- std_sel is registered once (std_q). A change means std_q differs from std_active.
- All outputs are registered. An output change takes effect on the clock edge of the state entry that requires it.
- IDLE: lasts 1 cycle; latches std_active<=std_q; goes to ASSERT_RST.
- ASSERT_RST:
  - mmcm_reset=1 and domain_reset all 1s.
  - Hold counter runs RST_HOLD cycles, then goes to WAIT_LOCK with mmcm_reset<=0.
- WAIT_LOCK:
  - Timeout counter increments every cycle.
  - Stable counter increments while locked_s=1 and clears to 0 on any locked_s=0.
  - Stable counter reaching LOCK_STABLE goes to RELEASE and sets retry_count<=0.
  - Timeout counter reaching LOCK_TIMEOUT with no qualification: retry_count+1. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to ASSERT_RST.
  - If qualification and timeout occur on the same cycle, qualification wins.
- RELEASE:
  - Stagger counter starts at 0 on entry. domain_reset[i] clears when the counter equals i*STAGGER.
  - One cycle after domain_reset[NUM_DOMAINS-1] clears, go to RUN with ready<=1.
  - If locked_s=0 during RELEASE, go to ASSERT_RST. All domain_reset bits re-assert on the same edge.
- RUN:
  - locked_s=0: go to ASSERT_RST. ready<=0 and domain_reset<=all 1s on the same edge. retry_count unchanged.
  - std_q != std_active: go to IDLE. ready<=0 and domain_reset<=all 1s. The new standard is latched in IDLE.
  - If both occur on the same cycle, go to IDLE (the standard change has priority).
- FAULT:
  - fault=1, mmcm_reset=1, domain_reset all 1s, ready=0.
  - Left only by reset_n or by a std_sel change. Exit goes to IDLE with fault<=0 and retry_count<=0.
- A std_sel change during ASSERT_RST, WAIT_LOCK or RELEASE aborts the attempt. Go to IDLE; retry_count is not incremented.
- Counter widths use $clog2 of (max value + 1). Counters saturate, never wrap.
- Invariants:
  - ready=1 implies domain_reset=0 and mmcm_reset=0.
  - mmcm_reset=1 implies domain_reset all 1s.
- Mid-operation reset_n assertion returns all outputs to their reset values immediately, without waiting for clk_in.

Decomposition:
- Package dot4x_clk_pkg holds:
  - the state enum (IDLE, ASSERT_RST, WAIT_LOCK, RELEASE, RUN, FAULT);
  - standard constants STD_NTSC=2'd0 and STD_PAL=2'd1;
  - a function that maps reserved std_sel codes to NTSC.
- One sub-module, sync_2ff: a 2-flop synchroniser with async active-low reset, reused for locked.
- MMCM primitives stay outside this block.

Test Plan (RST_HOLD=4, LOCK_STABLE=8, LOCK_TIMEOUT=40, STAGGER=3, NUM_DOMAINS=3, MAX_RETRIES=2):
- Nominal bring-up: release reset_n, raise locked 10 cycles later.
  - mmcm_reset falls at cycle 5.
  - domain_reset bits clear 0,3,6 cycles after the first RELEASE cycle; ready rises 1 cycle after the last clears.
  - retry_count=0.
- Glitchy lock: locked high 7 cycles, low 1, then steady.
  - Qualification happens only after 8 continuous synchronised-high cycles.
  - No retry is counted.
- Timeout and fault: locked held low.
  - After 40 WAIT_LOCK cycles, retry_count=1 and mmcm_reset re-asserts for 4 cycles.
  - After the second timeout, fault=1, retry_count=2, and the block stays in FAULT.
- Lock loss in RUN: drop locked.
  - 2 cycles after the drop (synchroniser delay), the next edge gives ready=0, domain_reset=3'b111, mmcm_reset=1.
  - Full re-sequence completes once lock returns.
- Standard switch: std_sel 0->1 in RUN.
  - ready drops, std_active becomes 1 in IDLE, and a new sequence runs.
  - Repeat the switch while in FAULT and check that fault clears.
- Async reset mid-RELEASE: pulse reset_n low between clk_in edges.
  - All outputs return to reset values before the next edge.
